inv_key_schedule: RTL

Iterative inverse AES key scheduler. It is loaded with the final Nk-word window of the expanded key schedule and walks the schedule backwards one word per cycle, recovering each earlier word from later ones. It emits the 128-bit round keys in descending order (round Nr down to round 0) through a valid/ready handshake. It feeds the decryption datapath so that the full schedule never has to be stored.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/inv_key_word_step.sv | 24 ++
 rtl/inv_key_schedule.sv | 122 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, rcon constants, S-box and word helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_SUB,
    STEP_ROT_SUB_RCON
  } step_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } ks_state_e;

  localparam logic [7:0] INV_XTIME_POLY = 8'h8D;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  // Rcon of the highest multiple of Nk inside the final window.
  function automatic logic [7:0] rcon_init(input int nk);
    case (nk)
      6:       return 8'h80;
      8:       return 8'h40;
      default: return 8'h36;
    endcase
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ INV_XTIME_POLY) : (x >> 1);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Byte 0 lives in [7:0], so (b0,b1,b2,b3) -> (b1,b2,b3,b0) is a right rotate by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

endpackage

// File: rtl/inv_key_word_step.sv
// One backward key-schedule step: recovers w[i-Nk] from w[i] and w[i-1].
module inv_key_word_step
  import aes_pkg::*;
(
  input  logic [31:0] w_i,
  input  logic [31:0] w_prev_i,
  input  logic [7:0]  rcon_i,
  input  step_mode_e  mode_i,
  output logic [31:0] w_o
);

  logic [31:0] t;

  always_comb begin
    t = w_prev_i;
    case (mode_i)
      STEP_SUB:          t = sub_word(w_prev_i);
      STEP_ROT_SUB_RCON: t = sub_word(rot_word(w_prev_i)) ^ {24'h0, rcon_i};
      default:           t = w_prev_i;
    endcase
    w_o = w_i ^ t;
  end

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative inverse AES key scheduler: walks the schedule backwards one word per cycle
// and hands out round keys Nr..0 over a valid/ready handshake.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [32*Nk-1:0]  last_key,
  input  logic              key_ready,
  output logic [127:0]      round_key,
  output logic [3:0]        round_idx,
  output logic              key_valid,
  output logic              busy,
  output logic              done
);

  localparam int NR     = nr_of(Nk);
  localparam int J_INIT = 4 * (NR + 1) - Nk;

  ks_state_e   state_q;
  logic [31:0] win_q [Nk];
  logic [5:0]  j_q;
  logic [3:0]  p_q;
  logic [7:0]  rcon_q;
  logic        done_q;

  logic [32*Nk-1:0] win_flat;
  logic [5:0]       key_off;
  logic [5:0]       i_idx;
  logic [5:0]       i_mod;
  logic             emit;
  step_mode_e       mode;
  logic [31:0]      new_word;
  logic [127:0]     key_mux;

  for (genvar gi = 0; gi < Nk; gi++) begin : g_flat
    assign win_flat[32*gi +: 32] = win_q[gi];
  end

  assign emit    = (state_q == ST_RUN) && ({p_q, 2'b00} >= j_q);
  assign key_off = {p_q, 2'b00} - j_q;
  assign i_idx   = j_q + 6'(Nk - 1);
  assign i_mod   = i_idx % 6'(Nk);

  always_comb begin
    mode = STEP_NONE;
    if (i_mod == 6'd0)
      mode = STEP_ROT_SUB_RCON;
    else if (Nk == 8 && i_mod == 6'd4)
      mode = STEP_SUB;
  end

  inv_key_word_step u_step (
    .w_i      (win_q[Nk-1]),
    .w_prev_i (win_q[Nk-2]),
    .rcon_i   (rcon_q),
    .mode_i   (mode),
    .w_o      (new_word)
  );

  // Emitted key sits at window offset 4p-j, always within 0..Nk-4.
  always_comb begin
    key_mux = '0;
    for (int k = 0; k <= Nk - 4; k++) begin
      if (key_off == 6'(k))
        key_mux = win_flat[32*k +: 128];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      p_q     <= '0;
      rcon_q  <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < Nk; k++) win_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < Nk; k++) win_q[k] <= last_key[32*k +: 32];
            j_q     <= 6'(J_INIT);
            p_q     <= 4'(NR);
            rcon_q  <= rcon_init(Nk);
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (emit) begin
            if (key_ready) begin
              if (p_q == 4'd0) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
              end else begin
                p_q <= p_q - 4'd1;
              end
            end
          end else begin
            win_q[0] <= new_word;
            for (int k = 1; k < Nk; k++) win_q[k] <= win_q[k-1];
            j_q <= j_q - 6'd1;
            if (mode == STEP_ROT_SUB_RCON)
              rcon_q <= inv_xtime(rcon_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign key_valid = emit;
  assign round_key = emit ? key_mux : '0;
  assign round_idx = emit ? p_q : 4'd0;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule
